// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared command encodings, FSM states and mode-register fields
//
// Purpose : constants and types shared by the SDRAM controller files.
// Ports   : none (package).

package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;

  typedef enum logic [3:0] {
    INIT_WAIT,
    INIT_PRE,
    INIT_TRP,
    INIT_AREF,
    INIT_TRFC,
    INIT_MRS,
    INIT_TMRD,
    IDLE,
    AREF,
    AREF_TRFC
  } sdram_state_e;

  // Mode register fields
  localparam logic [2:0] MR_BURST_LEN_4 = 3'b010;
  localparam logic       MR_BURST_SEQ   = 1'b0;
  localparam logic [2:0] MR_CAS_LAT_3   = 3'b011;
  localparam logic [1:0] MR_OP_STD      = 2'b00;
  localparam logic       MR_WB_BURST    = 1'b0;

  localparam logic [11:0] MODE_REG_DEFAULT =
    {2'b00, MR_WB_BURST, MR_OP_STD, MR_CAS_LAT_3, MR_BURST_SEQ, MR_BURST_LEN_4};

  // addr[10]=1 selects all banks for PRECHARGE
  localparam logic [11:0] ADDR_PRE_ALL = 12'h400;

endpackage

// File: rtl/sdram_init.sv
// rtl/sdram_init.sv - power-up initialisation sequencer for SDR SDRAM
//
// Purpose : power-up wait, precharge-all, INIT_AREF_CNT auto-refreshes,
//           load mode register; then parks and holds init_done high.
// Ports   : clk, rst        clock, synchronous active-high reset
//           cmd[3:0]        registered {cs_n,ras_n,cas_n,we_n}
//           addr[11:0]      registered address for the current command
//           init_done       registered, high once the sequence completed

module sdram_init
  import sdram_pkg::*;
#(
  parameter int          T_POWERUP     = 10000,
  parameter int          T_RP          = 2,
  parameter int          T_RFC         = 7,
  parameter int          T_MRD         = 2,
  parameter int          INIT_AREF_CNT = 8,
  parameter logic [11:0] MODE_REG      = MODE_REG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  cmd,
  output logic [11:0] addr,
  output logic        init_done
);

  localparam logic [13:0] WAIT_LAST  = 14'(T_POWERUP - 1);
  localparam logic [13:0] RP_LAST    = 14'(T_RP - 1);
  localparam logic [13:0] RFC_LAST   = 14'(T_RFC - 1);
  localparam logic [13:0] MRD_LAST   = 14'(T_MRD - 1);
  localparam logic [3:0]  AREF_TOTAL = 4'(INIT_AREF_CNT);

  sdram_state_e state;
  logic [13:0]  wait_cnt;
  logic [3:0]   aref_cnt;

  // Outputs are loaded on the edge that enters a command state, so the
  // command is on the pins for exactly the cycle the FSM sits in it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT_WAIT;
      wait_cnt  <= '0;
      aref_cnt  <= '0;
      cmd       <= CMD_NOP;
      addr      <= '0;
      init_done <= 1'b0;
    end else begin
      cmd  <= CMD_NOP;
      addr <= '0;
      case (state)
        INIT_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state    <= INIT_PRE;
            wait_cnt <= '0;
            cmd      <= CMD_PRE;
            addr     <= ADDR_PRE_ALL;
          end else begin
            wait_cnt <= wait_cnt + 14'd1;
          end
        end
        INIT_PRE: begin
          state    <= INIT_TRP;
          wait_cnt <= '0;
        end
        INIT_TRP: begin
          if (wait_cnt == RP_LAST) begin
            state    <= INIT_AREF;
            wait_cnt <= '0;
            cmd      <= CMD_AREF;
          end else begin
            wait_cnt <= wait_cnt + 14'd1;
          end
        end
        INIT_AREF: begin
          state    <= INIT_TRFC;
          wait_cnt <= '0;
          aref_cnt <= aref_cnt + 4'd1;
        end
        INIT_TRFC: begin
          if (wait_cnt == RFC_LAST) begin
            wait_cnt <= '0;
            if (aref_cnt < AREF_TOTAL) begin
              state <= INIT_AREF;
              cmd   <= CMD_AREF;
            end else begin
              state <= INIT_MRS;
              cmd   <= CMD_MRS;
              addr  <= MODE_REG;
            end
          end else begin
            wait_cnt <= wait_cnt + 14'd1;
          end
        end
        INIT_MRS: begin
          state    <= INIT_TMRD;
          wait_cnt <= '0;
        end
        INIT_TMRD: begin
          if (wait_cnt == MRD_LAST) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            init_done <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 14'd1;
          end
        end
        default: begin
          // Sequence complete: park here until the next reset.
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/sdram_ctrl_top.sv
// rtl/sdram_ctrl_top.sv - SDR SDRAM controller: init, periodic refresh, pin drive
//
// Purpose : runs the init sequencer, then issues an AUTO_REFRESH every
//           T_REFI cycles. No user data path; DQ is never driven.
// Ports   : sclk, srst              50 MHz clock, synchronous active-high reset
//           sdram_clk               inverted sclk for the device
//           sdram_cke               clock enable (always 1)
//           sdram_cs_n/ras_n/cas_n/we_n  command strobes
//           sdram_bank[1:0]         bank address (always 0 in this revision)
//           sdram_addr[11:0]        address bus
//           sdram_dqm[1:0]          byte masks (always 0)
//           sdram_dq[15:0]          data bus, held high-Z

module sdram_ctrl_top
  import sdram_pkg::*;
#(
  parameter int          T_POWERUP     = 10000,
  parameter int          T_RP          = 2,
  parameter int          T_RFC         = 7,
  parameter int          T_MRD         = 2,
  parameter int          INIT_AREF_CNT = 8,
  parameter int          T_REFI        = 780,
  parameter logic [11:0] MODE_REG      = MODE_REG_DEFAULT
) (
  input  logic        sclk,
  input  logic        srst,
  output logic        sdram_clk,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic [1:0]  sdram_bank,
  output logic [11:0] sdram_addr,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_dqm,
  inout  wire  [15:0] sdram_dq
);

  localparam logic [13:0] RFC_LAST  = 14'(T_RFC - 1);
  localparam logic [9:0]  REFI_LAST = 10'(T_REFI - 1);

  logic [3:0]   init_cmd;
  logic [11:0]  init_addr;
  logic         init_done;

  sdram_state_e ref_state;
  logic [13:0]  wait_cnt;
  logic [9:0]   ref_timer;
  logic         ref_req;
  logic [3:0]   ref_cmd;
  logic         timer_wrap;
  logic [3:0]   pin_cmd;

  sdram_init #(
    .T_POWERUP     (T_POWERUP),
    .T_RP          (T_RP),
    .T_RFC         (T_RFC),
    .T_MRD         (T_MRD),
    .INIT_AREF_CNT (INIT_AREF_CNT),
    .MODE_REG      (MODE_REG)
  ) u_init (
    .clk       (sclk),
    .rst       (srst),
    .cmd       (init_cmd),
    .addr      (init_addr),
    .init_done (init_done)
  );

  assign timer_wrap = init_done && (ref_timer == REFI_LAST);

  always_ff @(posedge sclk) begin
    if (srst) begin
      ref_timer <= '0;
    end else if (init_done) begin
      ref_timer <= timer_wrap ? 10'd0 : ref_timer + 10'd1;
    end
  end

  // Refresh FSM. ref_req is set by the timer and cleared on the edge that
  // issues the refresh; a wrap on that same edge wins, so no request is lost.
  always_ff @(posedge sclk) begin
    if (srst) begin
      ref_state <= INIT_WAIT;
      wait_cnt  <= '0;
      ref_req   <= 1'b0;
      ref_cmd   <= CMD_NOP;
    end else begin
      ref_cmd <= CMD_NOP;
      if (timer_wrap) begin
        ref_req <= 1'b1;
      end
      case (ref_state)
        IDLE: begin
          if (ref_req) begin
            ref_state <= AREF;
            ref_cmd   <= CMD_AREF;
            if (!timer_wrap) begin
              ref_req <= 1'b0;
            end
          end
        end
        AREF: begin
          ref_state <= AREF_TRFC;
          wait_cnt  <= '0;
        end
        AREF_TRFC: begin
          if (wait_cnt == RFC_LAST) begin
            ref_state <= IDLE;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 14'd1;
          end
        end
        default: begin
          // Init phase is owned by sdram_init; take over once it is done.
          if (init_done) begin
            ref_state <= IDLE;
          end
        end
      endcase
    end
  end

  // Both sources are flops and the select is a flop, so the pins change
  // only just after the sclk rising edge.
  assign pin_cmd    = init_done ? ref_cmd : init_cmd;
  assign sdram_addr = init_done ? 12'h000 : init_addr;

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pin_cmd;

  assign sdram_clk  = ~sclk;
  assign sdram_cke  = 1'b1;
  assign sdram_bank = 2'b00;
  assign sdram_dqm  = 2'b00;
  assign sdram_dq   = 16'hzzzz;

endmodule

// File: tb/tb_sdram_ctrl_top.sv
// tb/tb_sdram_ctrl_top.sv - self-checking bench for sdram_ctrl_top

module tb_sdram_ctrl_top;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  logic        sclk = 1'b0;
  logic        srst = 1'b1;
  wire         sdram_clk;
  wire         sdram_cke;
  wire         sdram_cs_n;
  wire  [1:0]  sdram_bank;
  wire  [11:0] sdram_addr;
  wire         sdram_ras_n;
  wire         sdram_cas_n;
  wire         sdram_we_n;
  wire  [1:0]  sdram_dqm;
  wire  [15:0] sdram_dq;

  always #10 sclk = ~sclk;

  sdram_ctrl_top dut (
    .sclk        (sclk),
    .srst        (srst),
    .sdram_clk   (sdram_clk),
    .sdram_cke   (sdram_cke),
    .sdram_cs_n  (sdram_cs_n),
    .sdram_bank  (sdram_bank),
    .sdram_addr  (sdram_addr),
    .sdram_ras_n (sdram_ras_n),
    .sdram_cas_n (sdram_cas_n),
    .sdram_we_n  (sdram_we_n),
    .sdram_dqm   (sdram_dqm),
    .sdram_dq    (sdram_dq)
  );

  wire [3:0] cmd = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: pin invariants every cycle and minimum NOP spacing after
  // each non-NOP command.
  int bus_bad  = 0;
  int gap_bad  = 0;
  int since    = 100000;
  int need_gap = 0;

  always @(negedge sclk) begin
    if (sdram_cke !== 1'b1 || sdram_dqm !== 2'b00 || sdram_clk !== 1'b1) bus_bad++;
    if (cmd === NOP) begin
      if (sdram_addr !== 12'h000 || sdram_bank !== 2'b00) bus_bad++;
      since++;
    end else begin
      if (since < need_gap) gap_bad++;
      since    = 0;
      need_gap = (cmd === AREF) ? 7 : 2;
    end
  end

  always @(posedge sclk) begin
    #5;
    if (sdram_clk !== 1'b0) bus_bad++;
  end

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [11:0] addr;
    logic [1:0]  bank;
    int          gap;   // NOP cycles expected before this command
  } vec_t;

  vec_t seq [12];

  task automatic wait_cmd(output int gap, output bit ok);
    gap = 0;
    ok  = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(negedge sclk);
      if (cmd !== NOP) begin
        ok = 1'b1;
        break;
      end
      gap++;
    end
  endtask

  task automatic apply_vec(input int i);
    int g;
    bit ok;
    wait_cmd(g, ok);
    check({seq[i].name, "_seen"}, 32'(ok), 32'd1);
    check({seq[i].name, "_gap"},  g, seq[i].gap);
    check({seq[i].name, "_cmd"},  32'(cmd), 32'(seq[i].cmd));
    check({seq[i].name, "_addr"}, 32'(sdram_addr), 32'(seq[i].addr));
    check({seq[i].name, "_bank"}, 32'(sdram_bank), 32'(seq[i].bank));
  endtask

  task automatic release_reset();
    // Released just after a reset edge, so the current cycle is the
    // first of the power-up NOP cycles.
    @(posedge sclk);
    #1 srst = 1'b0;
  endtask

  initial begin
    int g;
    bit ok;

    seq[0] = '{"pre", PRE, 12'h400, 2'b00, 10000};
    for (int i = 1; i <= 8; i++) begin
      seq[i] = '{$sformatf("init_aref%0d", i), AREF, 12'h000, 2'b00, (i == 1) ? 2 : 7};
    end
    seq[9]  = '{"mrs",  MRS,  12'h032, 2'b00, 7};
    seq[10] = '{"ref0", AREF, 12'h000, 2'b00, 783};
    seq[11] = '{"ref1", AREF, 12'h000, 2'b00, 779};

    // Reset values
    srst = 1'b1;
    repeat (5) @(negedge sclk);
    check("rst_cmd",  32'(cmd), 32'(NOP));
    check("rst_addr", 32'(sdram_addr), 32'h0);
    check("rst_bank", 32'(sdram_bank), 32'h0);
    check("rst_cke",  32'(sdram_cke), 32'h1);
    check("rst_dqm",  32'(sdram_dqm), 32'h0);
    release_reset();

    // Full init sequence and first periodic refreshes
    for (int i = 0; i < 12; i++) apply_vec(i);

    // Steady-state refresh interval
    for (int i = 0; i < 12; i++) begin
      wait_cmd(g, ok);
      check("ref_interval", g + 1, 780);
      check("ref_cmd", 32'(cmd), 32'(AREF));
    end

    // Reset during the tRFC wait after init refresh #4
    srst = 1'b1;
    repeat (2) @(negedge sclk);
    release_reset();
    for (int i = 0; i < 5; i++) apply_vec(i);
    repeat (3) @(negedge sclk);
    srst = 1'b1;
    @(negedge sclk);
    check("midrst_cmd",  32'(cmd), 32'(NOP));
    check("midrst_addr", 32'(sdram_addr), 32'h0);
    release_reset();
    for (int i = 0; i < 12; i++) apply_vec(i);

    // Reset in IDLE three cycles before the next refresh is due
    repeat (777) @(negedge sclk);
    srst = 1'b1;
    @(negedge sclk);
    check("idlerst_cmd", 32'(cmd), 32'(NOP));
    release_reset();
    wait_cmd(g, ok);
    check("idlerst_first_cmd", 32'(cmd), 32'(PRE));
    check("idlerst_gap", g, 10000);
    for (int i = 1; i < 11; i++) apply_vec(i);

    check("bus_invariants", bus_bad, 0);
    check("cmd_spacing", gap_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
